// File: rtl/nios_sampler_pio_arbiter_if.sv
// Bundle between the PIO write arbiter, its requesters and the PIO s1 slave.
//
// Handshake: a requester raises req[i] with req_data lane i valid and holds both
// stable until ack[i] pulses for one cycle. ack[i] is the ready/complete strobe:
// the write to the PIO is issued in that same cycle. req[i] still high the cycle
// after ack[i] is a fresh request. The PIO side is a zero-wait-state Avalon-MM
// write: chipselect=1 and write_n=0 for exactly one cycle, with no waitrequest.
interface nios_sampler_pio_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        ack;
    logic                      busy;
    logic [2:0]                grant_idx;
    logic [DATA_W-1:0]         shadow;
    logic [1:0]                pio_address;
    logic                      pio_chipselect;
    logic                      pio_write_n;
    logic [31:0]               pio_writedata;

    // Arbiter side: consumes requests, masters the PIO bus.
    modport master (
        input  req, req_data,
        output ack, busy, grant_idx, shadow,
        output pio_address, pio_chipselect, pio_write_n, pio_writedata
    );

    // Requester / observer side.
    modport slave (
        output req, req_data,
        input  ack, busy, grant_idx, shadow,
        input  pio_address, pio_chipselect, pio_write_n, pio_writedata
    );
endinterface

// File: rtl/nios_sampler_pio_arbiter.sv
// Round-robin arbiter sharing the PIO output data register among NUM_REQ
// requesters. One single-cycle Avalon-MM write per grant, followed by a
// GAP_CYCLES idle gap; a shadow register tracks the last value written.
module nios_sampler_pio_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          reset_n,
    nios_sampler_pio_arbiter_if.master    bus,
    output logic [1:0]                    state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        ptr_q, ptr_d;
    logic [2:0]        grant_q, grant_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] shadow_q, shadow_d;
    logic [3:0]        gap_q, gap_d;

    logic [2:0]        winner;
    logic [2:0]        hi_win, lo_win;
    logic              hi_found;
    logic [DATA_W-1:0] win_data;
    logic [NUM_REQ-1:0] ack_c;

    // Round-robin pick: lowest requesting index at or above ptr, else lowest overall.
    always_comb begin
        hi_found = 1'b0;
        hi_win   = 3'd0;
        lo_win   = 3'd0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (bus.req[j]) begin
                lo_win = 3'(j);
                if (3'(j) >= ptr_q) begin
                    hi_found = 1'b1;
                    hi_win   = 3'(j);
                end
            end
        end
        winner   = hi_found ? hi_win : lo_win;
        win_data = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (winner == 3'(j)) begin
                win_data = bus.req_data[j*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state logic: latch the winner in IDLE, commit shadow on WRITE exit, count the gap.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        data_d   = data_q;
        shadow_d = shadow_q;
        gap_d    = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    grant_d = winner;
                    data_d  = win_data;
                    ptr_d   = (winner == 3'(NUM_REQ - 1)) ? 3'd0 : winner + 3'd1;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                shadow_d = data_q;
                if (GAP_CYCLES == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_GAP;
                    gap_d   = 4'(GAP_CYCLES);
                end
            end
            ST_GAP: begin
                // Requests are deliberately not looked at here.
                if (gap_q <= 4'd1) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset drops any in-flight write and re-prioritises requester 0.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= 3'd0;
            grant_q  <= 3'd0;
            data_q   <= '0;
            shadow_q <= '0;
            gap_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            data_q   <= data_d;
            shadow_q <= shadow_d;
            gap_q    <= gap_d;
        end
    end

    // Ack decode: only the latched grantee, only in the WRITE cycle, so at most one bit.
    always_comb begin
        ack_c = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            ack_c[j] = (state_q == ST_WRITE) && (grant_q == 3'(j));
        end
    end

    assign bus.ack            = ack_c;
    assign bus.busy           = (state_q != ST_IDLE);
    assign bus.grant_idx      = grant_q;
    assign bus.shadow         = shadow_q;
    assign bus.pio_address    = 2'd0;
    assign bus.pio_chipselect = (state_q == ST_WRITE);
    assign bus.pio_write_n    = (state_q != ST_WRITE);
    assign bus.pio_writedata  = (state_q == ST_WRITE) ? {{(32-DATA_W){1'b0}}, data_q} : 32'd0;
    assign state_dbg          = state_q;

endmodule

// File: tb/tb_nios_sampler_pio_arbiter.sv
// Bench for the PIO write arbiter: one instance with a 2-cycle gap driven by a
// cycle-by-cycle vector table plus corner sequences, and one with no gap.
module tb_nios_sampler_pio_arbiter;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_a_n;
    logic       rst_b_n;
    logic [1:0] st_a;
    logic [1:0] st_b;

    always #5 clk = ~clk;

    nios_sampler_pio_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) if_a ();
    nios_sampler_pio_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) if_b ();

    nios_sampler_pio_arbiter #(.NUM_REQ(4), .DATA_W(8), .GAP_CYCLES(2)) dut_a (
        .clk       (clk),
        .reset_n   (rst_a_n),
        .bus       (if_a.master),
        .state_dbg (st_a)
    );

    nios_sampler_pio_arbiter #(.NUM_REQ(4), .DATA_W(8), .GAP_CYCLES(0)) dut_b (
        .clk       (clk),
        .reset_n   (rst_b_n),
        .bus       (if_b.master),
        .state_dbg (st_b)
    );

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_a(input string tag, input logic cs, input logic wr_n,
                           input logic [31:0] wdata, input logic [3:0] ack,
                           input logic busy, input logic [2:0] grant, input logic [7:0] shadow);
        chk({tag, ".cs"},     32'(if_a.pio_chipselect), 32'(cs));
        chk({tag, ".wr_n"},   32'(if_a.pio_write_n),    32'(wr_n));
        chk({tag, ".wdata"},  if_a.pio_writedata,       wdata);
        chk({tag, ".ack"},    32'(if_a.ack),            32'(ack));
        chk({tag, ".busy"},   32'(if_a.busy),           32'(busy));
        chk({tag, ".grant"},  32'(if_a.grant_idx),      32'(grant));
        chk({tag, ".shadow"}, 32'(if_a.shadow),         32'(shadow));
        chk({tag, ".addr"},   32'(if_a.pio_address),    32'd0);
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst_n;
        logic [3:0]  req;
        logic [31:0] data;
        logic        cs;
        logic        wr_n;
        logic [31:0] wdata;
        logic [3:0]  ack;
        logic        busy;
        logic [2:0]  grant;
        logic [7:0]  shadow;
    } vec_t;

    vec_t vecs[26];

    function automatic vec_t mk(input logic r, input logic [3:0] q, input logic [31:0] d,
                                input logic cs, input logic wn, input logic [31:0] wd,
                                input logic [3:0] a, input logic b, input logic [2:0] g,
                                input logic [7:0] s);
        vec_t v;
        v.rst_n = r;  v.req = q;   v.data = d;  v.cs = cs;   v.wr_n = wn;
        v.wdata = wd; v.ack = a;   v.busy = b;  v.grant = g; v.shadow = s;
        return v;
    endfunction

    localparam logic [31:0] DA = 32'h0000_00A5;
    localparam logic [31:0] DD = 32'h1312_1110;

    initial begin
        int last_wr;
        int n_wr;
        logic [31:0] e;

        // reset + single request from requester 0
        vecs[0]  = mk(0, 4'h0, DA, 0, 1, 32'h0,  4'h0, 0, 0, 8'h00);
        vecs[1]  = mk(1, 4'h1, DA, 1, 0, 32'hA5, 4'h1, 1, 0, 8'h00);
        vecs[2]  = mk(1, 4'h0, DA, 0, 1, 32'h0,  4'h0, 1, 0, 8'hA5);
        vecs[3]  = mk(1, 4'h0, DA, 0, 1, 32'h0,  4'h0, 1, 0, 8'hA5);
        vecs[4]  = mk(1, 4'h0, DA, 0, 1, 32'h0,  4'h0, 0, 0, 8'hA5);
        // reset, then all four requesting: 10,11,12 spaced 4 cycles
        vecs[5]  = mk(0, 4'h0, DD, 0, 1, 32'h0,  4'h0, 0, 0, 8'h00);
        vecs[6]  = mk(1, 4'hF, DD, 1, 0, 32'h10, 4'h1, 1, 0, 8'h00);
        vecs[7]  = mk(1, 4'hF, DD, 0, 1, 32'h0,  4'h0, 1, 0, 8'h10);
        vecs[8]  = mk(1, 4'hF, DD, 0, 1, 32'h0,  4'h0, 1, 0, 8'h10);
        vecs[9]  = mk(1, 4'hF, DD, 0, 1, 32'h0,  4'h0, 0, 0, 8'h10);
        vecs[10] = mk(1, 4'hF, DD, 1, 0, 32'h11, 4'h2, 1, 1, 8'h10);
        vecs[11] = mk(1, 4'hF, DD, 0, 1, 32'h0,  4'h0, 1, 1, 8'h11);
        vecs[12] = mk(1, 4'hF, DD, 0, 1, 32'h0,  4'h0, 1, 1, 8'h11);
        vecs[13] = mk(1, 4'hF, DD, 0, 1, 32'h0,  4'h0, 0, 1, 8'h11);
        vecs[14] = mk(1, 4'hF, DD, 1, 0, 32'h12, 4'h4, 1, 2, 8'h11);
        vecs[15] = mk(1, 4'hF, DD, 0, 1, 32'h0,  4'h0, 1, 2, 8'h12);
        // after grant to 2, only 0 and 2 request: ptr=3 wraps to 0, then 2
        vecs[16] = mk(1, 4'h5, DD, 0, 1, 32'h0,  4'h0, 1, 2, 8'h12);
        vecs[17] = mk(1, 4'h5, DD, 0, 1, 32'h0,  4'h0, 0, 2, 8'h12);
        vecs[18] = mk(1, 4'h5, DD, 1, 0, 32'h10, 4'h1, 1, 0, 8'h12);
        vecs[19] = mk(1, 4'h5, DD, 0, 1, 32'h0,  4'h0, 1, 0, 8'h10);
        vecs[20] = mk(1, 4'h5, DD, 0, 1, 32'h0,  4'h0, 1, 0, 8'h10);
        vecs[21] = mk(1, 4'h5, DD, 0, 1, 32'h0,  4'h0, 0, 0, 8'h10);
        vecs[22] = mk(1, 4'h5, DD, 1, 0, 32'h12, 4'h4, 1, 2, 8'h10);
        vecs[23] = mk(1, 4'h0, DD, 0, 1, 32'h0,  4'h0, 1, 2, 8'h12);
        vecs[24] = mk(1, 4'h0, DD, 0, 1, 32'h0,  4'h0, 1, 2, 8'h12);
        vecs[25] = mk(1, 4'h0, DD, 0, 1, 32'h0,  4'h0, 0, 2, 8'h12);

        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        if_a.req = '0;  if_a.req_data = '0;
        if_b.req = '0;  if_b.req_data = '0;
        step();

        for (int i = 0; i < 26; i++) begin
            rst_a_n       = vecs[i].rst_n;
            if_a.req      = vecs[i].req;
            if_a.req_data = vecs[i].data;
            step();
            check_a($sformatf("v%0d", i), vecs[i].cs, vecs[i].wr_n, vecs[i].wdata,
                    vecs[i].ack, vecs[i].busy, vecs[i].grant, vecs[i].shadow);
        end

        // request arriving mid-gap waits for IDLE (ptr=3 now, so 0 wins first)
        if_a.req = 4'h1;  step();
        check_a("gap_w0", 1, 0, 32'h10, 4'h1, 1, 0, 8'h12);
        if_a.req = 4'h0;  step();
        chk("gap_g1.busy", 32'(if_a.busy), 32'd1);
        if_a.req = 4'h8;  step();
        check_a("gap_g2", 0, 1, 32'h0, 4'h0, 1, 0, 8'h10);
        step();
        check_a("gap_idle", 0, 1, 32'h0, 4'h0, 0, 0, 8'h10);
        step();
        check_a("gap_w3", 1, 0, 32'h13, 4'h8, 1, 3, 8'h10);

        // reset landing on a WRITE cycle drops the write
        if_a.req = 4'h0;  step(); step(); step();
        chk("rst_pre.state", 32'(st_a), 32'd0);
        if_a.req = 4'h2;  step();
        check_a("rst_w1", 1, 0, 32'h11, 4'h2, 1, 1, 8'h13);
        rst_a_n = 1'b0;   step();
        check_a("rst_hit", 0, 1, 32'h0, 4'h0, 0, 0, 8'h00);
        chk("rst_hit.state", 32'(st_a), 32'd0);
        rst_a_n = 1'b1;  if_a.req = 4'hF;  step();
        check_a("rst_ptr0", 1, 0, 32'h10, 4'h1, 1, 0, 8'h00);
        if_a.req = 4'h0;  step();
        chk("rst_after.shadow", 32'(if_a.shadow), 32'h10);

        // zero-gap instance: back-to-back writes every 2 cycles, alternating 0,1
        exp_q.push_back(32'h20);
        exp_q.push_back(32'h21);
        exp_q.push_back(32'h20);
        exp_q.push_back(32'h21);
        chk("b_reset.state", 32'(st_b), 32'd0);
        if_b.req_data = 32'h0000_2120;
        if_b.req      = 4'h3;
        rst_b_n       = 1'b1;
        last_wr = 0;
        n_wr    = 0;
        for (int c = 1; c <= 8; c++) begin
            step();
            chk($sformatf("b_c%0d.onehot", c), 32'($countones(if_b.ack) <= 1), 32'd1);
            chk($sformatf("b_c%0d.cs", c), 32'(if_b.pio_chipselect), 32'(c % 2));
            if (if_b.pio_chipselect) begin
                if (exp_q.size() == 0) begin
                    chk($sformatf("b_c%0d.extra_write", c), 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("b_c%0d.wdata", c), if_b.pio_writedata, e);
                    chk($sformatf("b_c%0d.ack", c), 32'(if_b.ack), e[0] ? 32'h2 : 32'h1);
                    chk($sformatf("b_c%0d.state", c), 32'(st_b), 32'd1);
                    if (n_wr > 0) chk($sformatf("b_c%0d.spacing", c), 32'(c - last_wr), 32'd2);
                    last_wr = c;
                    n_wr++;
                end
            end else begin
                chk($sformatf("b_c%0d.busy", c), 32'(if_b.busy), 32'd0);
            end
        end
        chk("b_pending_writes", 32'(exp_q.size()), 32'd0);
        if_b.req = 4'h0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
